// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding and counter sizing used by serial_subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must index bits 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational full-subtractor cell: d = x - y - bin, built from two half-subtractors.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    always_comb begin
        hs1_d = x ^ y;
        hs1_b = ~x & y;
        d     = hs1_d ^ bin;
        hs2_b = ~hs1_d & bin;
        bout  = hs1_b | hs2_b;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp the result to zero when the subtraction borrows.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             d_bit;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bor_q),
        .d    (d_bit),
        .bout (bout)
    );

    // Result fills from the MSB side; after WIDTH shifts bit 0 lands at the LSB.
    assign res_next = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    res_d   = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d = res_next;
                bor_d = bout;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d    = '0;
                    borrow_d = bout;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d   = bout ? '0 : res_next;
`else
                    diff_d   = res_next;
`endif
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            bor_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            bor_q    <= bor_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        busy   = (state_q == StRun);
        done   = (state_q == StDone);
        diff   = diff_q;
        borrow = borrow_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors, monitor pops on done.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_push  = 0;
    int unsigned n_done  = 0;
    int          cyc     = 0;

    logic [WIDTH:0] exp_q[$];
    int             done_times[$];
    logic [WIDTH-1:0] last_diff = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] d, input logic bw);
`ifdef SERIAL_SUB_SAT_EN
        return bw ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic bw);
        exp_q.push_back({sat(d, bw), bw});
        n_push++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [WIDTH:0] e;
            n_done++;
            done_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e[WIDTH:1]));
                check("borrow", 32'(borrow), 32'(e[0]));
            end
        end
    end

    // Called #1 after a posedge while the DUT is idle; returns #1 after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] ja, input logic [WIDTH-1:0] jb);
        start = 1'b1;
        a     = ja;
        b     = jb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ja;
        b     = jb ^ 8'h5C;
    endtask

    task automatic run_job(input logic [WIDTH-1:0] ja, input logic [WIDTH-1:0] jb,
                           input logic [WIDTH-1:0] ed, input logic eb, input bit repulse);
        int nb;
        int dc;
        bit stable;
        nb     = 0;
        dc     = 0;
        stable = 1'b1;
        push_exp(ed, eb);
        launch(ja, jb);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                if (diff !== last_diff) stable = 1'b0;
            end
            if (repulse && i == 3) begin
                start = 1'b1;
                a     = 8'h01;
                b     = 8'h01;
            end
            if (repulse && i == 4) start = 1'b0;
            if (done) begin
                dc = i;
                break;
            end
        end
        check("busy_cycles", 32'(nb), 32'(WIDTH));
        check("done_cycle", 32'(dc), 32'(WIDTH + 1));
        check("diff_held_in_run", 32'(stable), 32'd1);
        last_diff = sat(ed, eb);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int nd;
        int nt;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1);
        check("single_done_after_repulse", 32'(n_done), 32'd1);
        run_job(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_job(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_job(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
        run_job(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

        // Abort in RUN cycle 4; no expectation is queued for this job.
        launch(8'hAA, 8'h55);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        last_diff = '0;
        @(posedge clk);
        #1;
        run_job(8'hAA, 8'h55, 8'h55, 1'b0, 1'b0);

        // start held high: three back-to-back jobs.
        push_exp(8'h37, 1'b0);
        push_exp(8'hFF, 1'b1);
        push_exp(8'h64, 1'b0);
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h23;
        @(posedge clk);
        #1;
        a = 8'h30;
        b = 8'h31;
        wait_done("b2b_done0");
        @(posedge clk);
        @(posedge clk);
        #1;
        a = 8'hC8;
        b = 8'h64;
        wait_done("b2b_done1");
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_done2");
        @(posedge clk);
        #1;

        nt = done_times.size();
        check("b2b_done_count", 32'(nt >= 3), 32'd1);
        if (nt >= 3) begin
            check("b2b_spacing0", 32'(done_times[nt-2] - done_times[nt-3]), 32'(WIDTH + 2));
            check("b2b_spacing1", 32'(done_times[nt-1] - done_times[nt-2]), 32'(WIDTH + 2));
        end

        repeat (5) @(posedge clk);
        nd = exp_q.size();
        check("scoreboard_drained", 32'(nd), 32'd0);
        check("total_done_pulses", 32'(n_done), 32'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
